// File: rtl/grid_pkg.sv
// grid_pkg: shared FSM state type and default packet length limit for the grid DMA arbiter
package grid_pkg;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, FLUSH} state_e;
  localparam int GRID_MAX_PKT_LEN = 1100;
endpackage

// File: rtl/grid_dma_arbiter.sv
// grid_dma_arbiter: round-robin packet arbiter of two AXI-Stream sources onto one DMA stream
module grid_dma_arbiter
  import grid_pkg::*;
#(
  parameter int IQ_WIDTH    = 16,
  parameter int MAX_PKT_LEN = GRID_MAX_PKT_LEN,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [IQ_WIDTH-1:0]  s0_axis_tdata,
  input  logic                 s0_axis_tvalid,
  input  logic                 s0_axis_tlast,
  output logic                 s0_axis_tready,
  input  logic [IQ_WIDTH-1:0]  s1_axis_tdata,
  input  logic                 s1_axis_tvalid,
  input  logic                 s1_axis_tlast,
  output logic                 s1_axis_tready,
  output logic [IQ_WIDTH-1:0]  m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  input  logic [7:0]           cfg_int_every_i,
  output logic [1:0]           grant_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt0_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt1_o,
  output logic                 trunc_o,
  output logic                 int_o
);
  localparam int BW = $clog2(MAX_PKT_LEN + 1);
  state_e state_q, state_d;
  logic last_grant_q, last_grant_d, flush_src_q, flush_src_d;
  logic trunc_q, trunc_d, int_q, int_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d, pkt_cnt1_q, pkt_cnt1_d;
  logic [7:0] int_cnt_q, int_cnt_d, int_inc;
  logic sel, granted, at_max, src_valid, src_last, src_ready, fire, done, pick;
  logic [IQ_WIDTH-1:0] src_data;
  // Datapath mux: the owning source (granted or being flushed) is steered by the state register
  always_comb begin
    sel            = (state_q == GRANT1) || (state_q == FLUSH && flush_src_q);
    granted        = (state_q == GRANT0) || (state_q == GRANT1);
    at_max         = beat_q == BW'(MAX_PKT_LEN - 1);
    src_valid      = sel ? s1_axis_tvalid : s0_axis_tvalid;
    src_last       = sel ? s1_axis_tlast : s0_axis_tlast;
    src_data       = sel ? s1_axis_tdata : s0_axis_tdata;
    src_ready      = granted ? m_axis_tready : (state_q == FLUSH);
    s0_axis_tready = src_ready & ~sel;
    s1_axis_tready = src_ready & sel;
    m_axis_tvalid  = granted & src_valid;
    m_axis_tdata   = granted ? src_data : '0;
    m_axis_tlast   = granted & (src_last | at_max);
    fire           = src_valid & src_ready;
    done           = fire & src_last;
    pick           = (s0_axis_tvalid & s1_axis_tvalid) ? ~last_grant_q : s1_axis_tvalid;
  end
  // Next-state: arbitration, beat limit with truncation/flush, packet and interrupt counting
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    flush_src_d  = flush_src_q;
    beat_d       = beat_q;
    trunc_d      = trunc_q;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    int_cnt_d    = int_cnt_q;
    int_inc      = int_cnt_q + 8'd1;
    int_d        = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (s0_axis_tvalid | s1_axis_tvalid) state_d = pick ? GRANT1 : GRANT0;
      end
      GRANT0, GRANT1: if (fire) begin
        beat_d = beat_q + BW'(1);
        if (src_last) state_d = IDLE;
        else if (at_max) begin
          state_d     = FLUSH;
          flush_src_d = sel;
          trunc_d     = 1'b1;
        end
      end
      FLUSH: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (done) begin
      last_grant_d = sel;
      pkt_cnt0_d   = sel ? pkt_cnt0_q : pkt_cnt0_q + CNT_WIDTH'(1);
      pkt_cnt1_d   = sel ? pkt_cnt1_q + CNT_WIDTH'(1) : pkt_cnt1_q;
      int_d        = (cfg_int_every_i != 8'd0) && (int_inc >= cfg_int_every_i);
      int_cnt_d    = int_d ? 8'd0 : int_inc;
    end
  end
  // State and counter registers; last_grant resets to 1 so s0 wins the first tie
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      flush_src_q  <= 1'b0;
      beat_q       <= '0;
      trunc_q      <= 1'b0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      int_cnt_q    <= '0;
      int_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      flush_src_q  <= flush_src_d;
      beat_q       <= beat_d;
      trunc_q      <= trunc_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
      int_cnt_q    <= int_cnt_d;
      int_q        <= int_d;
    end
  end
  assign grant_o    = {state_q == GRANT1, state_q == GRANT0};
  assign pkt_cnt0_o = pkt_cnt0_q;
  assign pkt_cnt1_o = pkt_cnt1_q;
  assign trunc_o    = trunc_q;
  assign int_o      = int_q;
endmodule

// File: tb/tb_grid_dma_arbiter.sv
// tb_grid_dma_arbiter: scoreboard bench for the two-source packet arbiter
module tb_grid_dma_arbiter;
  localparam int W = 16;
  localparam int MAXL = 8;
  logic clk = 1'b0, reset_ni = 1'b0;
  logic [W-1:0] s0_axis_tdata = '0, s1_axis_tdata = '0, m_axis_tdata;
  logic s0_axis_tvalid = 1'b0, s0_axis_tlast = 1'b0, s0_axis_tready;
  logic s1_axis_tvalid = 1'b0, s1_axis_tlast = 1'b0, s1_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
  logic [7:0] cfg_int_every_i = '0;
  logic [1:0] grant_o;
  logic [15:0] pkt_cnt0_o, pkt_cnt1_o;
  logic trunc_o, int_o;
  int n_tests = 0, n_fail = 0;
  bit mon_en = 1'b1, rand_en = 1'b0, gap_chk = 1'b0;
  int flushed = 0;
  logic [W:0] q0[$], q1[$];
  int ord[$], int_at[$];
  grid_dma_arbiter #(.IQ_WIDTH(W), .MAX_PKT_LEN(MAXL), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .cfg_int_every_i(cfg_int_every_i), .grant_o(grant_o), .pkt_cnt0_o(pkt_cnt0_o), .pkt_cnt1_o(pkt_cnt1_o),
    .trunc_o(trunc_o), .int_o(int_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic rdy(input int src);
    return src != 0 ? s1_axis_tready : s0_axis_tready;
  endfunction
  // Sink ready: always high, or 50% random when rand_en
  initial forever begin
    @(posedge clk);
    #1 m_axis_tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  // Monitor: pop expected beats from the owning source's queue on every output handshake
  always @(negedge clk) if (mon_en) begin
    logic [W:0] e;
    if (gap_chk) begin
      check("gap_grant", 32'(grant_o), 0);
      check("gap_valid", 32'(m_axis_tvalid), 0);
      gap_chk = 1'b0;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (grant_o[1]) begin
        check("q1_nonempty", 32'(q1.size() > 0), 1);
        e = q1.size() > 0 ? q1.pop_front() : '0;
      end else begin
        check("q0_nonempty", 32'(q0.size() > 0), 1);
        e = q0.size() > 0 ? q0.pop_front() : '0;
      end
      check("beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(e));
      if (m_axis_tlast) begin
        ord.push_back(int'(grant_o[1]));
        gap_chk = 1'b1;
      end
    end
    if ((s0_axis_tvalid && s0_axis_tready || s1_axis_tvalid && s1_axis_tready) && !m_axis_tvalid) flushed++;
    if (int_o) int_at.push_back(int'(pkt_cnt0_o) + int'(pkt_cnt1_o));
  end
  task automatic drive(input int src, input logic [W-1:0] d, input logic v, input logic l);
    if (src == 0) begin s0_axis_tdata = d; s0_axis_tvalid = v; s0_axis_tlast = l; end
    else begin s1_axis_tdata = d; s1_axis_tvalid = v; s1_axis_tlast = l; end
  endtask
  // One packet; valid stays high afterwards so back-to-back packets are continuous
  task automatic send_pkt(input int src, input int id, input int n);
    for (int b = 0; b < n; b++) begin
      logic [W-1:0] d;
      logic l;
      int cnt;
      @(posedge clk);
      #1;
      d = {1'(src), 7'(id), 8'(b)};
      l = (b == n - 1);
      if (b < MAXL) begin
        if (src == 0) q0.push_back({l || b == MAXL - 1, d});
        else q1.push_back({l || b == MAXL - 1, d});
      end
      drive(src, d, 1'b1, l);
      cnt = 0;
      @(negedge clk);
      while (!rdy(src) && cnt < 500) begin
        @(negedge clk);
        cnt++;
      end
      check("tready_wait", 32'(rdy(src)), 1);
    end
  endtask
  task automatic run_pkts(input int src, input int id0, input int npk, input int len, input bit rnd);
    for (int p = 0; p < npk; p++) send_pkt(src, id0 + p, rnd ? int'($urandom_range(1, 6)) : len);
    @(posedge clk);
    #1 drive(src, '0, 1'b0, 1'b0);
  endtask
  task automatic do_reset;
    reset_ni = 1'b0;
    drive(0, '0, 1'b0, 1'b0);
    drive(1, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_ni = 1'b1;
    ord.delete();
    int_at.delete();
    flushed = 0;
  endtask
  task automatic drain;
    repeat (6) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_grant", 32'(grant_o), 0);
    check("rst_mvalid", 32'(m_axis_tvalid), 0);
    check("rst_cnt0", 32'(pkt_cnt0_o), 0);
    check("rst_trunc", 32'(trunc_o), 0);
    // Single requester, 4-beat packets
    run_pkts(0, 1, 3, 4, 1'b0);
    drain();
    check("t1_cnt0", 32'(pkt_cnt0_o), 3);
    check("t1_cnt1", 32'(pkt_cnt1_o), 0);
    check("t1_npkt", 32'(ord.size()), 3);
    // Both requesters continuously valid, 3-beat packets: strict alternation
    do_reset();
    fork
      run_pkts(0, 10, 2, 3, 1'b0);
      run_pkts(1, 20, 2, 3, 1'b0);
    join
    drain();
    check("t2_npkt", 32'(ord.size()), 4);
    for (int i = 0; i < 4 && i < ord.size(); i++) check($sformatf("t2_order%0d", i), 32'(ord[i]), 32'(i % 2));
    // Exactly MAXL beats with tlast is not truncated; 12 beats is
    do_reset();
    run_pkts(0, 30, 1, MAXL, 1'b0);
    drain();
    check("t3_no_trunc", 32'(trunc_o), 0);
    run_pkts(1, 31, 1, 12, 1'b0);
    drain();
    check("t3_trunc", 32'(trunc_o), 1);
    check("t3_flushed", 32'(flushed), 4);
    check("t3_cnt1", 32'(pkt_cnt1_o), 1);
    // Interrupt every 3 packets over 7 packets
    do_reset();
    cfg_int_every_i = 8'd3;
    fork
      run_pkts(0, 40, 4, 2, 1'b0);
      run_pkts(1, 50, 3, 2, 1'b0);
    join
    drain();
    check("t4_nint", 32'(int_at.size()), 2);
    for (int i = 0; i < 2 && i < int_at.size(); i++) check($sformatf("t4_int_at%0d", i), 32'(int_at[i]), 32'(3 * (i + 1)));
    // Disabled interrupt, then lowering the threshold below the running count
    do_reset();
    cfg_int_every_i = 8'd0;
    run_pkts(0, 60, 4, 2, 1'b0);
    drain();
    check("t5_noint", 32'(int_at.size()), 0);
    cfg_int_every_i = 8'd2;
    run_pkts(1, 64, 1, 2, 1'b0);
    drain();
    check("t5_nint", 32'(int_at.size()), 1);
    if (int_at.size() > 0) check("t5_int_at", 32'(int_at[0]), 5);
    // Random sink backpressure, random lengths from both sources
    do_reset();
    cfg_int_every_i = 8'd0;
    rand_en = 1'b1;
    fork
      run_pkts(0, 70, 5, 0, 1'b1);
      run_pkts(1, 80, 5, 0, 1'b1);
    join
    rand_en = 1'b0;
    drain();
    check("t6_cnt0", 32'(pkt_cnt0_o), 5);
    check("t6_cnt1", 32'(pkt_cnt1_o), 5);
    // Asynchronous reset on beat 2 of a 5-beat packet
    mon_en = 1'b0;
    @(posedge clk);
    #1 drive(0, 16'h0a00, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !s0_axis_tready; i++) @(negedge clk);
    @(posedge clk);
    #1 drive(0, 16'h0a01, 1'b1, 1'b0);
    @(negedge clk);
    check("t7_pre_valid", 32'(m_axis_tvalid), 1);
    #1 reset_ni = 1'b0;
    #1;
    check("t7_grant", 32'(grant_o), 0);
    check("t7_mvalid", 32'(m_axis_tvalid), 0);
    check("t7_mlast", 32'(m_axis_tlast), 0);
    check("t7_mdata", 32'(m_axis_tdata), 0);
    check("t7_rdy0", 32'(s0_axis_tready), 0);
    check("t7_rdy1", 32'(s1_axis_tready), 0);
    check("t7_cnt0", 32'(pkt_cnt0_o), 0);
    check("t7_cnt1", 32'(pkt_cnt1_o), 0);
    check("t7_int", 32'(int_o), 0);
    drive(1, 16'h8b00, 1'b1, 1'b0);
    @(posedge clk);
    #1 reset_ni = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t7_first_tie", 32'(grant_o), 1);
    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/grid_dma_arbiter.md
GRID_DMA_ARBITER -- requirements
Module: grid_dma_arbiter

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 16, width of every tdata bus.
REQ-002 SHALL have parameter MAX_PKT_LEN, default 1100, the maximum beats per packet before forced termination.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, the width of the packet counters.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 reset_ni  in  1  reset, asynchronous, active-low.
REQ-006 s0_axis_tdata / s0_axis_tvalid / s0_axis_tlast  in  IQ_WIDTH/1/1  requester 0 packet stream.
REQ-007 s0_axis_tready  out  1  requester 0 ready.
REQ-008 s1_axis_tdata / s1_axis_tvalid / s1_axis_tlast  in  IQ_WIDTH/1/1  requester 1 packet stream.
REQ-009 s1_axis_tready  out  1  requester 1 ready.
REQ-010 m_axis_tdata / m_axis_tvalid / m_axis_tlast  out  IQ_WIDTH/1/1  stream to AXI-DMAC.
REQ-011 m_axis_tready  in  1  DMAC ready.
REQ-012 cfg_int_every_i  in  8  packets per interrupt; 0 disables the interrupt.
REQ-013 grant_o  out  2  one-hot current owner; 00 when idle.
REQ-014 pkt_cnt0_o / pkt_cnt1_o  out  CNT_WIDTH  completed packets per requester, wrapping.
REQ-015 trunc_o  out  1  sticky flag: a packet was force-terminated.
REQ-016 int_o  out  1  one-cycle interrupt pulse.

Function
REQ-017 SHALL use FSM states IDLE, GRANT0, GRANT1, FLUSH.
REQ-018 IDLE: only s0 tvalid -> GRANT0; only s1 tvalid -> GRANT1; both -> the requester not in last_grant (round robin); neither -> stay in IDLE.
REQ-019 SHALL set last_grant to 1 at reset, so s0 wins the first tie.
REQ-020 Arbitration SHALL cost exactly one IDLE cycle between packets; grant_o and the mux update on the state register.
REQ-021 GRANTx: m_axis_* = sx_axis_* combinationally, sx_axis_tready = m_axis_tready, other requester tready = 0.
REQ-022 In IDLE and FLUSH, m_axis_tvalid SHALL be 0.
REQ-023 Packet granularity: the grant SHALL be held until the beat with tvalid&tready&tlast completes; next state IDLE, last_grant <= x, pkt_cntx += 1.
REQ-024 A beat counter SHALL count accepted beats in GRANTx; on beat MAX_PKT_LEN without tlast, SHALL drive m_axis_tlast = 1 on that beat, set trunc_o, and go to FLUSH.
REQ-025 FLUSH: sx_axis_tready = 1 and beats are discarded until the source tlast is accepted; then go to IDLE and count the packet.
REQ-026 Interrupt counter SHALL increment per completed packet (either requester); on reaching cfg_int_every_i it SHALL pulse int_o for one cycle and clear.
REQ-027 A cfg_int_every_i change SHALL take effect at the next comparison; a counter value already >= the new value SHALL fire on the next packet completion.
REQ-028 pkt_cnt SHALL wrap from 2^CNT_WIDTH-1 to 0 with no flag.
REQ-029 A deasserted source tvalid mid-packet SHALL keep the grant (no timeout).
REQ-030 m_axis_tready low SHALL stall without losing or duplicating beats.

Reset
REQ-031 Reset assertion SHALL immediately force state IDLE, grant_o 00, all tready 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, counters 0, trunc_o 0, int_o 0, last_grant 1.
REQ-032 Reset mid-packet SHALL abandon the packet; sources are expected to be reset together with the block.

Structure
REQ-033 The state enum and MAX_PKT_LEN default SHALL be defined in shared package grid_pkg.
REQ-034 No sub-module is required; the beat/interrupt counters stay inline.

Verification
REQ-035 Only s0 sends 4-beat packets, tready=1 -> 4 beats out per packet, 1 idle cycle between, grant_o=01, pkt_cnt0_o=1 per packet.
REQ-036 s0 and s1 both valid continuously with 3-beat packets -> order s0,s1,s0,s1; no beat interleaving inside a packet.
REQ-037 MAX_PKT_LEN=8, s1 sends 12 beats -> 8 beats out, tlast on beat 8, trunc_o=1, 4 beats flushed, pkt_cnt1_o=1.
REQ-038 cfg_int_every_i=3, 7 packets -> int_o pulses after packets 3 and 6 only; cfg_int_every_i=0 -> no pulses.
REQ-039 Random m_axis_tready (50%) -> output beat sequence identical to input, no drops or duplicates.
REQ-040 reset_ni low on beat 2 of a 5-beat packet -> outputs 0 in the same cycle; after release, s0 wins the first tie.
